// File: rtl/shift_register_s_p_rx.sv
// Serial-to-parallel trigger-link receiver.
// Rebuilds LSB-first frames bounded by sync/last and strobes good words.
module shift_register_s_p_rx #(
  parameter int WIDTH       = 100,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync,
  input  logic                   serial_in,
  input  logic                   last,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  output logic                   frame_error,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [WIDTH-1:0]       shreg, shreg_n;
  logic [WIDTH-1:0]       shifted;
  logic [WIDTH-1:0]       dout_n;
  logic                   dv_n, fe_n;
  logic [COUNT_WIDTH-1:0] fc_n;

  assign shifted = {serial_in, shreg[WIDTH-1:1]};
  assign busy    = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      data_out    <= dout_n;
      data_valid  <= dv_n;
      frame_error <= fe_n;
      frame_count <= fc_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    dout_n  = data_out;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    fc_n    = frame_count;
    unique case (state)
      IDLE: begin
        if (sync) begin
          shreg_n = shifted;
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // A fresh sync always wins, even alongside last.
        if (sync) begin
          fe_n    = 1'b1;
          shreg_n = shifted;
          cnt_n   = CW'(1);
        end else if (cnt != LAST_IDX) begin
          if (last) begin
            fe_n    = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            shreg_n = shifted;
            cnt_n   = cnt + CW'(1);
          end
        end else if (last) begin
          shreg_n = shifted;
          dout_n  = shifted;
          dv_n    = 1'b1;
          fc_n    = frame_count + COUNT_WIDTH'(1);
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          fe_n    = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_register_s_p_rx.sv
// Bench for shift_register_s_p_rx: frame-level table plus random frames
// expanded into per-cycle expectations, and a hand-written reset case.
module tb_shift_register_s_p_rx;

  localparam int W    = 100;
  localparam int CW   = 16;
  localparam int MAXC = 6000;

  typedef enum int {GOOD, MISS, EARLY, ABORT, GAP} kind_t;

  typedef struct {
    kind_t        kind;
    logic [W-1:0] word;
    int           k;
    int           exp_at;
    bit           exp_good;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sync = 1'b0;
  logic          serial_in = 1'b0;
  logic          last = 1'b0;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          frame_error;
  logic          busy;
  logic [CW-1:0] frame_count;

  shift_register_s_p_rx #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync        (sync),
    .serial_in   (serial_in),
    .last        (last),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t vq[$];
  bit           s_sync [MAXC];
  bit           s_last [MAXC];
  bit           s_ser  [MAXC];
  bit           e_valid[MAXC];
  bit           e_err  [MAXC];
  bit           e_busy [MAXC];
  bit           e_set  [MAXC];
  logic [W-1:0] e_word [MAXC];
  int           ncyc;

  function automatic vec_t mk(kind_t kd, logic [W-1:0] w, int k,
                              int at, bit good);
    vec_t v;
    v.kind = kd; v.word = w; v.k = k; v.exp_at = at; v.exp_good = good;
    return v;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sync = 1'b0; last = 1'b0; serial_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expand the frame list into per-cycle stimulus and expectations.
  task automatic build();
    int t = 0;
    int n;
    for (int c = 0; c < MAXC; c++) begin
      s_sync[c] = 0; s_last[c] = 0; s_ser[c] = 0;
      e_valid[c] = 0; e_err[c] = 0; e_busy[c] = 0; e_set[c] = 0;
      e_word[c] = '0;
    end
    foreach (vq[i]) begin
      if (vq[i].kind == GAP) begin
        for (int j = 0; j < vq[i].k; j++) begin
          s_ser[t]  = 1'($urandom_range(0, 1));
          s_last[t] = 1'($urandom_range(0, 1));
          t++;
        end
      end else begin
        case (vq[i].kind)
          EARLY:   n = vq[i].k + 1;
          ABORT:   n = vq[i].k;
          default: n = W;
        endcase
        for (int j = 0; j < n; j++) begin
          s_sync[t+j] = (j == 0);
          s_ser[t+j]  = vq[i].word[j];
          s_last[t+j] = (j == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (vq[i].kind == GOOD)  s_last[t+W-1] = 1'b1;
        if (vq[i].kind == EARLY) s_last[t+vq[i].k] = 1'b1;
        for (int j = 1; j < n; j++) e_busy[t+j] = 1'b1;
        if (vq[i].kind == ABORT) e_busy[t+n] = 1'b1;
        if (vq[i].exp_good) begin
          e_valid[t+vq[i].exp_at] = 1'b1;
          e_set[t+vq[i].exp_at]   = 1'b1;
          e_word[t+vq[i].exp_at]  = vq[i].word;
        end else begin
          e_err[t+vq[i].exp_at] = 1'b1;
        end
        t += n;
      end
    end
    ncyc = t + 2;
  endtask

  task automatic run(string tag);
    logic [W-1:0]  dout_m = '0;
    logic [CW-1:0] cnt_m  = '0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (e_set[c]) begin
        dout_m = e_word[c];
        cnt_m  = cnt_m + 1'b1;
      end
      chk($sformatf("%s c%0d valid", tag, c), W'(data_valid), W'(e_valid[c]));
      chk($sformatf("%s c%0d error", tag, c), W'(frame_error), W'(e_err[c]));
      chk($sformatf("%s c%0d busy", tag, c), W'(busy), W'(e_busy[c]));
      chk($sformatf("%s c%0d data", tag, c), data_out, dout_m);
      chk($sformatf("%s c%0d count", tag, c), W'(frame_count), W'(cnt_m));
      sync      = s_sync[c];
      last      = s_last[c];
      serial_in = s_ser[c];
    end
  endtask

  task automatic send_bits(logic [W-1:0] w, int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      sync      = (j == 0);
      serial_in = w[j];
      last      = (j == W - 1);
    end
    @(negedge clk);
    sync = 1'b0; last = 1'b0; serial_in = 1'b0;
  endtask

  logic [W-1:0] wa, wb, wc, wr;
  kind_t kd;
  int    k;

  initial begin
    wa = 100'h5_A5A5_A5A5_0123_4567_89AB_CDEF;
    wb = ~wa;
    wc = 100'h1_2345_6789_ABCD_EF01_2345_6789;

    #1;
    do_reset();
    chk("reset data", data_out, '0);
    chk("reset valid", W'(data_valid), '0);
    chk("reset error", W'(frame_error), '0);
    chk("reset busy", W'(busy), '0);
    chk("reset count", W'(frame_count), '0);

    vq.delete();
    vq.push_back(mk(GOOD,  wa, 0,  100, 1'b1));
    vq.push_back(mk(GOOD,  wb, 0,  100, 1'b1));
    vq.push_back(mk(MISS,  wc, 0,  100, 1'b0));
    vq.push_back(mk(EARLY, wc, 50, 51,  1'b0));
    vq.push_back(mk(GAP,   '0, 20, -1,  1'b0));
    vq.push_back(mk(ABORT, wb, 40, 41,  1'b0));
    vq.push_back(mk(GOOD,  wc, 0,  100, 1'b1));
    vq.push_back(mk(GAP,   '0, 3,  -1,  1'b0));
    build();
    run("dir");

    vq.delete();
    for (int f = 0; f < 24; f++) begin
      for (int j = 0; j < W; j++) wr[j] = 1'($urandom_range(0, 1));
      kd = kind_t'($urandom_range(0, 3));
      if (f == 23) kd = GOOD;
      case (kd)
        GOOD:    vq.push_back(mk(GOOD, wr, 0, W, 1'b1));
        MISS:    vq.push_back(mk(MISS, wr, 0, W, 1'b0));
        EARLY: begin
          k = $urandom_range(1, W - 2);
          vq.push_back(mk(EARLY, wr, k, k + 1, 1'b0));
        end
        default: begin
          k = $urandom_range(1, W - 1);
          vq.push_back(mk(ABORT, wr, k, k + 1, 1'b0));
        end
      endcase
      if (kd != ABORT && $urandom_range(0, 1) == 1)
        vq.push_back(mk(GAP, '0, $urandom_range(1, 4), -1, 1'b0));
    end
    build();
    run("rnd");

    do_reset();
    send_bits(wa, W);
    chk("rst pre valid", W'(data_valid), W'(1'b1));
    chk("rst pre data", data_out, wa);
    for (int j = 0; j <= 60; j++) begin
      @(negedge clk);
      sync      = (j == 0);
      serial_in = wb[j];
      last      = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst async data", data_out, '0);
    chk("rst async busy", W'(busy), '0);
    chk("rst async count", W'(frame_count), '0);
    chk("rst async error", W'(frame_error), '0);
    chk("rst async valid", W'(data_valid), '0);
    sync = 1'b0; serial_in = 1'b0;
    @(negedge clk);
    chk("rst hold error", W'(frame_error), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst post error", W'(frame_error), '0);
    chk("rst post busy", W'(busy), '0);
    send_bits(wc, W);
    chk("rst clean valid", W'(data_valid), W'(1'b1));
    chk("rst clean data", data_out, wc);
    chk("rst clean count", W'(frame_count), W'(1));
    chk("rst clean error", W'(frame_error), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
